// File: rtl/timers_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timers_pkg
// Description : Shared encodings for the timer subsystem: edge-select codes
//               used by capture channels and capture state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package timers_pkg;

    // edge_sel encodings
    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_NONE = 2'b11;

    // Capture channel states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2
    } cap_state_e;

endpackage
`default_nettype wire

// File: rtl/timers_sync.sv
`default_nettype none
// ============================================================================
// Module      : timers_sync
// Description : Multi-flop synchronizer for a single asynchronous timer input.
//               All stages reset to 0. Depth below 2 is raised to 2.
// Ports       : clk_i  - destination clock
//               rst_ni - asynchronous active-low reset
//               d_i    - asynchronous input
//               q_o    - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module timers_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    localparam int C_DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [C_DEPTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[C_DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[C_DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/timers_capture.sv
`default_nettype none
// ============================================================================
// Module      : timers_capture
// Description : Input-capture channel. Measures the number of timer_clk cycles
//               between successive qualifying edges of cap_in, latches the
//               interval, keeps sticky valid/overflow flags and produces an
//               optionally stretched interrupt pulse.
// Ports       : timer_clk      - block clock
//               timer_resetn   - asynchronous active-low reset
//               capture_en     - channel enable
//               edge_sel       - 00 rise, 01 fall, 10 both, 11 none
//               cap_in         - asynchronous event line
//               int_clr        - clears cap_valid / overflow
//               captured_value - last interval, zero-extended to 32 bits
//               cap_valid      - sticky capture flag
//               overflow       - sticky saturated-capture flag
//               interrupt      - capture pulse, stretched by TIMER_PULSE_EXTD
// Revision    : 1.0 - initial release
// ============================================================================
module timers_capture
    import timers_pkg::*;
#(
    parameter int TIMER_WIDTH      = 8,
    parameter int TIMER_PULSE_EXTD = 0,
    parameter int SYNC_STAGES      = 2
) (
    input  logic        timer_clk,
    input  logic        timer_resetn,
    input  logic        capture_en,
    input  logic [1:0]  edge_sel,
    input  logic        cap_in,
    input  logic        int_clr,
    output logic [31:0] captured_value,
    output logic        cap_valid,
    output logic        overflow,
    output logic        interrupt
);

    localparam logic [TIMER_WIDTH-1:0] C_ONE = TIMER_WIDTH'(1);
    localparam logic [TIMER_WIDTH-1:0] C_MAX = '1;
    localparam int C_EXT = (TIMER_PULSE_EXTD > 3) ? 3 : TIMER_PULSE_EXTD;
    // Selects which delayed copies of the raw pulse widen the interrupt
    localparam logic [2:0] C_EXT_MASK = (C_EXT == 0) ? 3'b000 :
                                        (C_EXT == 1) ? 3'b001 :
                                        (C_EXT == 2) ? 3'b011 : 3'b111;

    logic                   w_s_in;
    logic                   w_qedge;
    logic                   prev_q;
    cap_state_e             state_q,   state_d;
    logic [TIMER_WIDTH-1:0] counter_q, counter_d;
    logic                   sat_q,     sat_d;
    logic [TIMER_WIDTH-1:0] capval_q,  capval_d;
    logic                   valid_q,   valid_d;
    logic                   ovf_q,     ovf_d;
    logic                   raw_q,     raw_d;
    logic [2:0]             ext_q;

    timers_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (timer_clk),
        .rst_ni (timer_resetn),
        .d_i    (cap_in),
        .q_o    (w_s_in)
    );

    // Edge history runs regardless of capture_en, so enabling while the line
    // is static never sees a stale transition.
    always_comb begin
        w_qedge = 1'b0;
        case (edge_sel)
            EDGE_RISE: w_qedge = w_s_in & ~prev_q;
            EDGE_FALL: w_qedge = ~w_s_in & prev_q;
            EDGE_BOTH: w_qedge = w_s_in ^ prev_q;
            EDGE_NONE: w_qedge = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        sat_d     = sat_q;
        capval_d  = capval_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        raw_d     = 1'b0;

        // Clear first so that a capture in the same cycle re-sets the flags
        if (int_clr) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end

        if (!capture_en) begin
            state_d   = ST_IDLE;
            counter_d = '0;
            sat_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_ARM;
                    counter_d = '0;
                end
                ST_ARM: begin
                    // First edge only starts the interval
                    counter_d = '0;
                    if (w_qedge) begin
                        counter_d = C_ONE;
                        state_d   = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (w_qedge) begin
                        capval_d  = counter_q;
                        counter_d = C_ONE;
                        valid_d   = 1'b1;
                        if (sat_q) begin
                            ovf_d = 1'b1;
                        end
                        sat_d     = 1'b0;
                        raw_d     = 1'b1;
                    end else begin
                        if (counter_q != C_MAX) begin
                            counter_d = counter_q + C_ONE;
                        end
                        // Flag once the counter holds all-ones so an interval
                        // of exactly 2^W-1 also reports overflow.
                        if (counter_d == C_MAX) begin
                            sat_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    counter_d = '0;
                    sat_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge timer_clk or negedge timer_resetn) begin
        if (!timer_resetn) begin
            prev_q    <= 1'b0;
            state_q   <= ST_IDLE;
            counter_q <= '0;
            sat_q     <= 1'b0;
            capval_q  <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            raw_q     <= 1'b0;
            ext_q     <= '0;
        end else begin
            prev_q    <= w_s_in;
            state_q   <= state_d;
            counter_q <= counter_d;
            sat_q     <= sat_d;
            capval_q  <= capval_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            raw_q     <= raw_d;
            ext_q     <= {ext_q[1:0], raw_q};
        end
    end

    // Back-to-back captures overlap in the OR and merge into one pulse
    assign interrupt = raw_q | (|(ext_q & C_EXT_MASK));
    assign cap_valid = valid_q;
    assign overflow  = ovf_q;

    generate
        if (TIMER_WIDTH < 32) begin : g_pad
            assign captured_value = {{(32-TIMER_WIDTH){1'b0}}, capval_q};
        end else begin : g_full
            assign captured_value = capval_q[31:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_timers_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_timers_capture
// Description : Self-checking bench for timers_capture. Two instances run in
//               lock-step (pulse extension 0 and 2). An event-level model
//               tracks the time of each qualifying edge and derives interval,
//               flags and interrupt windows from edge timestamps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timers_capture;

    localparam int MAXV = 255;
    localparam int LAT  = 2;   // drive-edge to capture-edge distance (2 sync flops)

    logic        clk = 1'b0;
    logic        rstn;
    logic        capture_en;
    logic [1:0]  edge_sel;
    logic        cap_in;
    logic        int_clr;
    logic [31:0] cv0, cv2;
    logic        vld0, vld2, ovf0, ovf2, irq0, irq2;
    logic [69:0] obs;

    always #5 clk = ~clk;

    timers_capture #(.TIMER_WIDTH(8), .TIMER_PULSE_EXTD(0), .SYNC_STAGES(2)) dut_e0 (
        .timer_clk(clk), .timer_resetn(rstn), .capture_en(capture_en),
        .edge_sel(edge_sel), .cap_in(cap_in), .int_clr(int_clr),
        .captured_value(cv0), .cap_valid(vld0), .overflow(ovf0), .interrupt(irq0));

    timers_capture #(.TIMER_WIDTH(8), .TIMER_PULSE_EXTD(2), .SYNC_STAGES(2)) dut_e2 (
        .timer_clk(clk), .timer_resetn(rstn), .capture_en(capture_en),
        .edge_sel(edge_sel), .cap_in(cap_in), .int_clr(int_clr),
        .captured_value(cv2), .cap_valid(vld2), .overflow(ovf2), .interrupt(irq2));

    assign obs = {cv0, vld0, ovf0, irq0, cv2, vld2, ovf2, irq2};

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // ---------------- reference model state ----------------
    int         cyc = 0;          // index of the last clock edge taken
    bit         en_at  [0:16383];
    logic [1:0] sel_at [0:16383];
    int         evq[$];           // pending line transitions: due_edge*2 + rising
    logic       prev_drv = 1'b0;
    int         last_t = -1;      // edge of last qualifying edge while enabled; -1 = not timing
    int         exp_cv = 0;
    logic       exp_valid = 1'b0;
    logic       exp_ovf = 1'b0;
    int         last_pulse = -100;

    function automatic logic [69:0] exp_vec();
        int   d;
        logic i0, i2;
        d  = cyc - last_pulse;
        i0 = (d == 0);
        i2 = (d >= 0) && (d <= 2);
        return {32'(exp_cv), exp_valid, exp_ovf, i0, 32'(exp_cv), exp_valid, exp_ovf, i2};
    endfunction

    task automatic model_reset();
        evq.delete();
        last_t     = -1;
        exp_cv     = 0;
        exp_valid  = 1'b0;
        exp_ovf    = 1'b0;
        last_pulse = -100;
        prev_drv   = 1'b0;
        en_at[cyc] = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, advance the model on
    // the rising edge, return at the next falling edge for sampling.
    task automatic step(input logic cin, input logic clr);
        int   e, diff;
        logic q, rise, capt;
        cap_in  = cin;
        int_clr = clr;
        e = cyc + 1;
        en_at[e]  = capture_en;
        sel_at[e] = edge_sel;
        if (cin !== prev_drv) evq.push_back((e + LAT) * 2 + int'(cin));
        prev_drv = cin;
        @(posedge clk);
        cyc  = e;
        q    = 1'b0;
        capt = 1'b0;
        if (evq.size() > 0 && evq[0] / 2 == cyc) begin
            rise = (evq[0] % 2) == 1;
            void'(evq.pop_front());
            q = rise ? (sel_at[cyc] == 2'b00 || sel_at[cyc] == 2'b10)
                     : (sel_at[cyc] == 2'b01 || sel_at[cyc] == 2'b10);
        end
        if (clr) begin
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
        end
        if (en_at[cyc] && en_at[cyc-1] && q) begin
            if (last_t >= 0) begin
                diff      = cyc - last_t;
                exp_cv    = (diff >= MAXV) ? MAXV : diff;
                exp_valid = 1'b1;
                if (diff >= MAXV) exp_ovf = 1'b1;
                last_pulse = cyc;
                capt = 1'b1;
            end
            last_t = cyc;
        end
        if (!en_at[cyc]) last_t = -1;
        if (capt) begin end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; capture_en = 1'b0; edge_sel = 2'b00; cap_in = 1'b0; int_clr = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs !== 70'd0) begin
            n_fail++; $display("FAIL reset_state got=%h exp=%h", obs, 70'd0);
        end else n_pass++;
        rstn = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end else n_pass++;
        end
    endtask

    task automatic test_rise10();
        edge_sel = 2'b00; capture_en = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 10; i++) begin
                step((i < 5) ? 1'b1 : 1'b0, 1'b0);
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fail++; $display("FAIL rise10 cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
                end else n_pass++;
            end
            if (p == 0) begin
                n_checks++;
                if (vld0 !== 1'b0) begin
                    n_fail++; $display("FAIL rise10_first_arms cap_valid=%b exp=0", vld0);
                end else n_pass++;
            end
        end
        n_checks++;
        if (cv0 !== 32'd10 || vld0 !== 1'b1) begin
            n_fail++; $display("FAIL rise10_value cv=%0d valid=%b exp cv=10 valid=1", cv0, vld0);
        end else n_pass++;
    endtask

    task automatic test_both();
        int hi0 = 0, hi2 = 0;
        edge_sel = 2'b10;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 10; i++) begin
                step((i < 4) ? 1'b1 : 1'b0, 1'b0);
                hi0 += int'(irq0);
                hi2 += int'(irq2);
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fail++; $display("FAIL both cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
                end else n_pass++;
            end
        end
        n_checks++;
        if (cv0 !== 32'd4) begin
            n_fail++; $display("FAIL both_value cv=%0d exp=4", cv0);
        end else n_pass++;
        n_checks++;
        if (hi0 !== 6 || hi2 !== 18) begin
            n_fail++; $display("FAIL both_irq_width hi0=%0d hi2=%0d exp 6 and 18", hi0, hi2);
        end else n_pass++;
    endtask

    task automatic test_overflow();
        edge_sel = 2'b00;
        for (int i = 0; i < 326; i++) begin
            step((i == 0 || i == 300 || i == 320) ? 1'b1 : 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL overflow cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end else n_pass++;
            if (i == 319) begin
                n_checks++;
                if (cv0 !== 32'd255 || ovf0 !== 1'b1) begin
                    n_fail++; $display("FAIL overflow_sat cv=%0d ovf=%b exp cv=255 ovf=1", cv0, ovf0);
                end else n_pass++;
            end
        end
        n_checks++;
        if (cv0 !== 32'd20 || ovf0 !== 1'b1) begin
            n_fail++; $display("FAIL overflow_sticky cv=%0d ovf=%b exp cv=20 ovf=1", cv0, ovf0);
        end else n_pass++;
    endtask

    task automatic test_clr_same();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);   // capture edge coincides with int_clr
        n_checks++;
        if (vld0 !== 1'b1 || cv0 !== 32'd6 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL clr_same_cycle valid=%b cv=%0d exp valid=1 cv=6", vld0, cv0);
        end else n_pass++;
        step(1'b0, 1'b1);
        n_checks++;
        if (vld0 !== 1'b0 || ovf0 !== 1'b0 || cv0 !== 32'd6) begin
            n_fail++; $display("FAIL clr_alone valid=%b ovf=%b cv=%0d exp 0 0 6", vld0, ovf0, cv0);
        end else n_pass++;
    endtask

    task automatic test_disable();
        edge_sel = 2'b00;
        for (int i = 0; i < 26; i++) begin
            if (i == 4)  capture_en = 1'b0;
            if (i == 8)  capture_en = 1'b1;
            step((i == 0 || i == 10 || i == 17) ? 1'b1 : 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL disable cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end else n_pass++;
        end
        n_checks++;
        if (cv0 !== 32'd7) begin
            n_fail++; $display("FAIL disable_value cv=%0d exp=7", cv0);
        end else n_pass++;
    endtask

    task automatic test_none();
        edge_sel = 2'b11;
        step(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL none cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end else n_pass++;
        end
        n_checks++;
        if (vld0 !== 1'b0 || vld2 !== 1'b0) begin
            n_fail++; $display("FAIL none_no_capture valid0=%b valid2=%b exp 0", vld0, vld2);
        end else n_pass++;
    endtask

    task automatic test_random();
        int   steps = 0;
        int   len;
        logic lvl = cap_in;
        while (steps < 1500) begin
            len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(250, 300))
                                                : int'($urandom_range(1, 12));
            lvl = ~lvl;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 99) == 0) capture_en = ~capture_en;
                if ($urandom_range(0, 49) == 0) edge_sel = 2'($urandom_range(0, 3));
                step(lvl, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
                steps++;
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
                end else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midop();
        edge_sel = 2'b00; capture_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step((i == 2 || i >= 6) ? 1'b1 : 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL midop_pre cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end else n_pass++;
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (obs !== 70'd0) begin
            n_fail++; $display("FAIL midop_async_reset got=%h exp=%h", obs, 70'd0);
        end else n_pass++;
        repeat (2) @(negedge clk);
        capture_en = 1'b0;
        rstn = 1'b1;
        model_reset();
        for (int i = 0; i < 14; i++) begin
            if (i == 4) capture_en = 1'b1;
            step(1'b1, 1'b0);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL midop_post cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end else n_pass++;
        end
        n_checks++;
        if (vld0 !== 1'b0 || irq0 !== 1'b0) begin
            n_fail++; $display("FAIL midop_no_false_edge valid=%b irq=%b exp 0 0", vld0, irq0);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rise10();
        test_both();
        test_overflow();
        test_clr_same();
        test_disable();
        test_none();
        test_random();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
